// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: the arbiter FSM state
// encoding, the default byte width and a small width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    // Default byte width; must match uart_tx data_in.
    localparam int DW_DEFAULT = 8;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // clog2 that never returns zero, so a counter always has at least one bit.
    function automatic int clog2_min1(input int v);
        int r;
        if (v <= 2) begin
            r = 1;
        end else begin
            r = $clog2(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: returns the first requesting index
// at or after the priority pointer, wrapping modulo NREQ.
// Ports:
//   i_req   [NREQ-1:0]          request vector
//   i_ptr   [clog2(NREQ)-1:0]   highest-priority index (must be < NREQ)
//   o_grant [NREQ-1:0]          one-hot grant (zero when no request)
//   o_idx   [clog2(NREQ)-1:0]   index of the granted requester
//   o_valid                     at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_idx,
    output logic                    o_valid
);

    localparam int IW = $clog2(NREQ);

    // Scan NREQ positions starting at the pointer; the first hit wins.
    always_comb begin
        int  j;
        logic found;
        j       = 0;
        found   = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr < NREQ, so one subtraction is enough to wrap.
            j = int'(i_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end else begin
                j = j;
            end
            if (!found && i_req[j]) begin
                found      = 1'b1;
                o_idx      = IW'(j);
                o_grant[j] = 1'b1;
            end else begin
                found = found;
            end
        end
        o_valid = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx between NREQ byte producers. Round-robin arbitration,
// optional packet lock (owner keeps the transmitter until a byte flagged
// last), one tx_start pulse per accepted byte, and an optional watchdog that
// aborts the wait for tx_done_tick.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   req_valid  [NREQ]     requester i has a byte
//   req_data   [NREQ*DW]  byte of requester i at [i*DW +: DW]
//   req_last   [NREQ]     byte ends a packet (releases the lock)
//   req_ready  [NREQ]     one-hot accept strobe (combinational, ARB only)
//   tx_start              one-cycle start pulse to uart_tx
//   tx_data    [DW]       registered byte to uart_tx
//   tx_done_tick          completion pulse from uart_tx
//   grant_id   [clog2]    current / last owner
//   busy                  high in START and WAIT
//   err_timeout           one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int DW          = DW_DEFAULT,
    parameter int TIMEOUT_CYC = 0,
    parameter bit LOCK_EN     = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    tx_start,
    output logic [DW-1:0]           tx_data,
    input  logic                    tx_done_tick,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int GW  = $clog2(NREQ);
    localparam int WDW = clog2_min1(TIMEOUT_CYC + 1);
    localparam bit WD_EN = (TIMEOUT_CYC > 0);
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    arb_state_t      r_state;
    arb_state_t      w_next_state;
    logic            r_lock;
    logic [GW-1:0]   r_ptr;
    logic [WDW-1:0]  r_wd_cnt;
    logic [DW-1:0]   r_tx_data;
    logic [GW-1:0]   r_grant_id;
    logic            r_err_timeout;

    logic [NREQ-1:0] w_owner_mask;
    logic [NREQ-1:0] w_eligible;
    logic [NREQ-1:0] w_grant;
    logic [GW-1:0]   w_win_idx;
    logic            w_win_valid;
    logic            w_win_last;
    logic [DW-1:0]   w_win_data;
    logic            w_done;
    logic            w_wd_hit;

    // Pointer increment that wraps at NREQ-1 (NREQ need not be a power of 2).
    function automatic logic [GW-1:0] inc_wrap(input logic [GW-1:0] v);
        logic [GW-1:0] r;
        if (v == GW'(NREQ - 1)) begin
            r = '0;
        end else begin
            r = v + GW'(1);
        end
        return r;
    endfunction

    // While locked only the current owner may win; everyone else is masked.
    assign w_owner_mask = NREQ'(1'b1) << r_grant_id;
    assign w_eligible   = r_lock ? (req_valid & w_owner_mask) : req_valid;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .i_req   (w_eligible),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_idx),
        .o_valid (w_win_valid)
    );

    assign w_win_last = req_last[w_win_idx];
    assign w_win_data = req_data[w_win_idx*DW +: DW];

    // Done only counts in WAIT; a coinciding done suppresses the timeout.
    assign w_done   = (r_state == ST_WAIT) && tx_done_tick;
    assign w_wd_hit = WD_EN && (r_state == ST_WAIT) && !tx_done_tick && (r_wd_cnt == WD_LAST);

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ARB: begin
                if (w_win_valid) begin
                    w_next_state = ST_START;
                end else begin
                    w_next_state = ST_ARB;
                end
            end
            ST_START: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_done || w_wd_hit) begin
                    w_next_state = ST_ARB;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            default: begin
                w_next_state = ST_ARB;
            end
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        req_ready = '0;
        tx_start  = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_ARB: begin
                req_ready = w_grant;
            end
            ST_START: begin
                tx_start = 1'b1;
                busy     = 1'b1;
            end
            ST_WAIT: begin
                busy = 1'b1;
            end
            default: begin
                req_ready = '0;
            end
        endcase
    end

    // Byte latch, owner, lock, rr pointer, watchdog and error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_data     <= '0;
            r_grant_id    <= '0;
            r_lock        <= 1'b0;
            r_ptr         <= '0;
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_wd_hit;
            case (r_state)
                ST_ARB: begin
                    if (w_win_valid) begin
                        r_tx_data  <= w_win_data;
                        r_grant_id <= w_win_idx;
                        r_lock     <= LOCK_EN & ~w_win_last;
                    end
                end
                ST_START: begin
                    r_wd_cnt <= '0;
                end
                ST_WAIT: begin
                    if (w_done) begin
                        // A locked owner keeps priority; otherwise rotate past it.
                        if (!r_lock) begin
                            r_ptr <= inc_wrap(r_grant_id);
                        end
                    end else if (w_wd_hit) begin
                        // Abort drops the lock so a stuck packet cannot starve others.
                        r_lock <= 1'b0;
                        r_ptr  <= inc_wrap(r_grant_id);
                    end else if (r_wd_cnt != {WDW{1'b1}}) begin
                        r_wd_cnt <= r_wd_cnt + WDW'(1);
                    end
                end
                default: begin
                    r_lock <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant_id;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed self-checking bench for uart_tx_arbiter (NREQ=4, DW=8,
// TIMEOUT_CYC=50, LOCK_EN=1). Inputs change and outputs are sampled 1 time
// unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        tx_done_tick;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int s0     = 0;

    uart_tx_arbiter #(
        .NREQ        (4),
        .DW          (8),
        .TIMEOUT_CYC (50),
        .LOCK_EN     (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
        .grant_id     (grant_id),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    always #5 clock = ~clock;

    // Count start pulses mid-cycle.
    always @(negedge clock) begin
        if (tx_start) starts = starts + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        req_valid    = 4'b0000;
        req_last     = 4'b0000;
        req_data     = 32'h0;
        tx_done_tick = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Called in ARB with inputs settled: expect grant g, byte d, then
    // 'waits' extra WAIT cycles before the done tick returns to ARB.
    task automatic serve(input string tag, input logic [1:0] g, input logic [7:0] d, input int waits);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
        tick();
        chk({tag, "_start"}, 32'(tx_start), 32'h1);
        chk({tag, "_data"},  32'(tx_data),  32'(d));
        chk({tag, "_gid"},   32'(grant_id), 32'(g));
        chk({tag, "_busyS"}, 32'(busy),     32'h1);
        chk({tag, "_rdyS"},  32'(req_ready), 32'h0);
        tick();
        chk({tag, "_startW"}, 32'(tx_start), 32'h0);
        for (int w = 0; w < waits; w++) begin
            tick();
            chk({tag, "_busyW"}, 32'(busy), 32'h1);
        end
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        #1;
        chk({tag, "_busyA"}, 32'(busy), 32'h0);
        chk({tag, "_dataHold"}, 32'(tx_data), 32'(d));
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        chk("rst_ready", 32'(req_ready),   32'h0);
        chk("rst_start", 32'(tx_start),    32'h0);
        chk("rst_data",  32'(tx_data),     32'h0);
        chk("rst_gid",   32'(grant_id),    32'h0);
        chk("rst_busy",  32'(busy),        32'h0);
        chk("rst_err",   32'(err_timeout), 32'h0);

        // ---------------- single requester ----------------
        req_valid      = 4'b0001;
        req_last       = 4'b0001;
        req_data[7:0]  = 8'hA5;
        #1;
        serve("single", 2'd0, 8'hA5, 3);
        req_valid = 4'b0000;
        #1;
        chk("single_idle_rdy", 32'(req_ready), 32'h0);
        tick();
        chk("single_idle_busy", 32'(busy), 32'h0);

        // ---------------- round robin ----------------
        do_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = 32'h13121110;
        #1;
        s0 = starts;
        serve("rr0", 2'd0, 8'h10, 0);
        serve("rr1", 2'd1, 8'h11, 0);
        serve("rr2", 2'd2, 8'h12, 0);
        serve("rr3", 2'd3, 8'h13, 0);
        serve("rr4", 2'd0, 8'h10, 0);
        chk("rr_start_count", 32'(starts - s0), 32'd5);

        // ---------------- packet lock ----------------
        do_reset();
        req_valid      = 4'b0011;
        req_last       = 4'b0010;
        req_data[7:0]  = 8'hC0;
        req_data[15:8] = 8'hD1;
        #1;
        serve("lock0", 2'd0, 8'hC0, 1);
        req_data[7:0] = 8'hC1;
        #1;
        serve("lock1", 2'd0, 8'hC1, 1);
        req_data[7:0] = 8'hC2;
        req_last      = 4'b0011;
        #1;
        serve("lock2", 2'd0, 8'hC2, 1);
        serve("lock_rel", 2'd1, 8'hD1, 1);

        // ---------------- lock stall ----------------
        do_reset();
        req_valid       = 4'b0101;
        req_last        = 4'b0100;
        req_data[7:0]   = 8'hE0;
        req_data[23:16] = 8'hE2;
        #1;
        serve("stall0", 2'd0, 8'hE0, 0);
        req_valid = 4'b0100;
        #1;
        for (int i = 0; i < 20; i++) begin
            chk("stall_ready", 32'(req_ready), 32'h0);
            chk("stall_busy",  32'(busy),      32'h0);
            tick();
        end
        req_valid     = 4'b0101;
        req_last      = 4'b0101;
        req_data[7:0] = 8'hE3;
        #1;
        serve("stall_ret", 2'd0, 8'hE3, 0);
        serve("stall_next", 2'd2, 8'hE2, 0);

        // ---------------- watchdog ----------------
        do_reset();
        req_valid      = 4'b0011;
        req_last       = 4'b0010;
        req_data[7:0]  = 8'hC5;
        req_data[15:8] = 8'hD6;
        #1;
        chk("wd_ready0", 32'(req_ready), 32'h1);
        tick();
        chk("wd_start0", 32'(tx_start), 32'h1);
        tick();
        chk("wd_err_entry", 32'(err_timeout), 32'h0);
        for (int i = 0; i < 49; i++) begin
            tick();
            chk("wd_err_early", 32'(err_timeout), 32'h0);
        end
        chk("wd_busy_late", 32'(busy), 32'h1);
        tick();
        chk("wd_err_pulse", 32'(err_timeout), 32'h1);
        chk("wd_busy_abort", 32'(busy), 32'h0);
        chk("wd_next_ready", 32'(req_ready), 32'h2);
        tick();
        chk("wd_err_clear", 32'(err_timeout), 32'h0);
        chk("wd_start1", 32'(tx_start), 32'h1);
        chk("wd_gid1", 32'(grant_id), 32'h1);
        chk("wd_data1", 32'(tx_data), 32'hD6);
        tick();
        for (int i = 0; i < 49; i++) begin
            tick();
        end
        chk("wd_coinc_busy", 32'(busy), 32'h1);
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        #1;
        chk("wd_coinc_err", 32'(err_timeout), 32'h0);
        chk("wd_coinc_busy2", 32'(busy), 32'h0);
        chk("wd_coinc_ready", 32'(req_ready), 32'h1);

        // ---------------- reset in WAIT ----------------
        do_reset();
        req_valid     = 4'b0001;
        req_last      = 4'b0000;
        req_data[7:0] = 8'hA0;
        #1;
        tick();
        tick();
        tick();
        tick();
        chk("rw_busy_pre", 32'(busy), 32'h1);
        reset     = 1'b1;
        req_valid = 4'b0000;
        tick();
        reset = 1'b0;
        #1;
        chk("rw_ready", 32'(req_ready),   32'h0);
        chk("rw_start", 32'(tx_start),    32'h0);
        chk("rw_data",  32'(tx_data),     32'h0);
        chk("rw_gid",   32'(grant_id),    32'h0);
        chk("rw_busy",  32'(busy),        32'h0);
        chk("rw_err",   32'(err_timeout), 32'h0);
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        #1;
        chk("rw_late_busy",  32'(busy),     32'h0);
        chk("rw_late_start", 32'(tx_start), 32'h0);
        req_valid       = 4'b0100;
        req_last        = 4'b0100;
        req_data[23:16] = 8'hB2;
        #1;
        serve("rw_after", 2'd2, 8'hB2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
